in_mux_stream: RTL and testbench

Parametrised, flow-controlled successor to the systolic-array input distributor. It accepts whole activation words through a valid/ready handshake and latches the weight-precision mode once per word. It then emits 1, 2 or 4 registered beats of 2-bit bricks, replicated and interleaved as the BitFusion fusion units expect. It sits between the activation buffer and the west-edge inputs of the systolic array, and supports arbitrary multiples of 32-bit width with full-throughput back-to-back words.

---
 rtl/in_mux_stream.sv | 181 ++++++++++++++++++
 tb/tb_in_mux_stream.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/in_mux_stream.sv
// in_mux_stream
// -------------
// Flow-controlled input distributor for the systolic array west edge.
// Accepts one activation word per valid/ready handshake, latches the
// weight-precision mode with it, and emits 1, 2 or 4 registered beats of
// 2-bit bricks laid out the way the BitFusion fusion units expect.
//
// Ports
//   clk              clock
//   RST              synchronous active-high reset
//   weight_bitwidth  one-hot mode (001 = 2b, 010 = 4b, 100 = 8b), sampled on accept
//   in_valid         upstream word valid
//   in_ready         block can accept a word this cycle
//   data_in          activation word (DATA_W bits, DATA_W multiple of 32)
//   out_valid        out_data holds a valid beat
//   out_ready        downstream consumes the beat this cycle
//   out_data         fused brick beat
//   out_last         beat is the last one of its word
//   out_beat         index of the beat within its word
//   err_mode         sticky flag: a word was accepted with a non-one-hot mode
module in_mux_stream #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [2:0]        weight_bitwidth,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [1:0]        out_beat,
  output logic              err_mode
);

  localparam int G = DATA_W / 32;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_d;
  logic [1:0]        ptr, ptr_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [2:0]        mode_q, mode_d;

  logic              valid_d;
  logic [DATA_W-1:0] data_d;
  logic              last_d;
  logic [1:0]        beat_d;
  logic              err_d;

  logic              advance;
  logic              accept;

  // Number of beats a word produces in a given mode; illegal modes emit
  // a single (zero) beat.
  function automatic logic [2:0] beats_of(input logic [2:0] mode);
    case (mode)
      3'b100:  beats_of = 3'd4;
      3'b010:  beats_of = 3'd2;
      default: beats_of = 3'd1;
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] mode);
    is_legal = (mode == 3'b001) || (mode == 3'b010) || (mode == 3'b100);
  endfunction

  // Build beat p of a word. In 8-bit mode each slot takes one byte and
  // replicates every brick four times; in 4-bit mode each slot takes a
  // byte pair and interleaves their bricks, each replicated twice.
  // 4-bit mode only ever has beats 0/1, so only p[0] is used there.
  function automatic logic [DATA_W-1:0] beat_data(input logic [DATA_W-1:0] word,
                                                  input logic [2:0]        mode,
                                                  input logic [1:0]        p);
    logic [DATA_W-1:0] res;
    logic [7:0]        a;
    logic [7:0]        c;
    res = '0;
    a   = '0;
    c   = '0;
    case (mode)
      3'b100: begin
        for (int j = 0; j < G; j++) begin
          a = word[8*(int'(p)*G + j) +: 8];
          res[32*j +: 32] = {{4{a[7:6]}}, {4{a[5:4]}}, {4{a[3:2]}}, {4{a[1:0]}}};
        end
      end
      3'b010: begin
        for (int j = 0; j < G; j++) begin
          a = word[8*(int'(p[0])*2*G + 2*j) +: 8];
          c = word[8*(int'(p[0])*2*G + 2*j + 1) +: 8];
          res[32*j +: 32] = {{2{c[7:6]}}, {2{a[7:6]}}, {2{c[5:4]}}, {2{a[5:4]}},
                             {2{c[3:2]}}, {2{a[3:2]}}, {2{c[1:0]}}, {2{a[1:0]}}};
        end
      end
      3'b001:  res = word;
      default: res = '0;
    endcase
    beat_data = res;
  endfunction

  // The output register can take a new beat when empty or being consumed.
  // in_ready follows out_ready combinationally so a new word can replace
  // the final beat of the previous one without a bubble.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && (state == IDLE) && !RST;
  assign accept   = in_valid && in_ready;

  // Next-state and next-output logic. Priority: a new word (only possible
  // in IDLE), then the next pending beat of the held word, then draining
  // the output register. Data, last and beat index hold when draining.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    word_d  = word_q;
    mode_d  = mode_q;
    valid_d = out_valid;
    data_d  = out_data;
    last_d  = out_last;
    beat_d  = out_beat;
    err_d   = err_mode;

    if (accept) begin
      valid_d = 1'b1;
      data_d  = beat_data(data_in, weight_bitwidth, 2'd0);
      beat_d  = 2'd0;
      last_d  = (beats_of(weight_bitwidth) == 3'd1);
      if (!is_legal(weight_bitwidth)) begin
        err_d = 1'b1;
      end
      if (beats_of(weight_bitwidth) != 3'd1) begin
        word_d  = data_in;
        mode_d  = weight_bitwidth;
        ptr_d   = 2'd1;
        state_d = BUSY;
      end
    end else if ((state == BUSY) && advance) begin
      valid_d = 1'b1;
      data_d  = beat_data(word_q, mode_q, ptr);
      beat_d  = ptr;
      last_d  = ({1'b0, ptr} == (beats_of(mode_q) - 3'd1));
      if ({1'b0, ptr} == (beats_of(mode_q) - 3'd1)) begin
        state_d = IDLE;
        ptr_d   = 2'd0;
      end else begin
        ptr_d = ptr + 2'd1;
      end
    end else if (advance) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset; reset drops any
  // pending beats of an in-flight word.
  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      word_q    <= '0;
      mode_q    <= 3'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_beat  <= 2'd0;
      err_mode  <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      word_q    <= word_d;
      mode_q    <= mode_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_last  <= last_d;
      out_beat  <= beat_d;
      err_mode  <= err_d;
    end
  end

endmodule

// File: tb/tb_in_mux_stream.sv
// tb_in_mux_stream
// ----------------
// Bench for in_mux_stream (DATA_W = 32). A queue-based model turns every
// observed word handshake into its list of expected beats; a monitor
// compares the DUT against the queue head every cycle, while the directed
// sequence pins specific beats with hand-computed literals.
module tb_in_mux_stream;

  localparam int DW = 32;
  localparam int G  = DW / 32;

  logic          clk;
  logic          RST;
  logic [2:0]    weight_bitwidth;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [1:0]    out_beat;
  logic          err_mode;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [1:0]    beat;
  } beat_t;

  beat_t q[$];
  logic  err_model  = 1'b0;
  logic  just_reset = 1'b1;

  in_mux_stream #(.DATA_W(DW)) dut (
    .clk             (clk),
    .RST             (RST),
    .weight_bitwidth (weight_bitwidth),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .data_in         (data_in),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_last        (out_last),
    .out_beat        (out_beat),
    .err_mode        (err_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected beat p of a word, from the brick rules using shifts and masks.
  function automatic logic [DW-1:0] modelBeat(input logic [DW-1:0] w,
                                              input logic [2:0]    m,
                                              input int            p);
    logic [DW-1:0] res;
    logic [DW-1:0] av;
    logic [DW-1:0] cv;
    logic [DW-1:0] ba;
    logic [DW-1:0] bc;
    res = '0;
    if (m == 3'b001) begin
      res = w;
    end else if (m == 3'b100) begin
      for (int j = 0; j < G; j++) begin
        av = (w >> (8 * (p * G + j))) & 'hFF;
        for (int k = 0; k < 4; k++) begin
          ba = (av >> (2 * k)) & 'h3;
          for (int r = 0; r < 4; r++) res = res | (ba << (32 * j + 8 * k + 2 * r));
        end
      end
    end else if (m == 3'b010) begin
      for (int j = 0; j < G; j++) begin
        av = (w >> (8 * (2 * p * G + 2 * j))) & 'hFF;
        cv = (w >> (8 * (2 * p * G + 2 * j + 1))) & 'hFF;
        for (int k = 0; k < 4; k++) begin
          ba = (av >> (2 * k)) & 'h3;
          bc = (cv >> (2 * k)) & 'h3;
          for (int r = 0; r < 2; r++) begin
            res = res | (ba << (32 * j + 8 * k + 2 * r));
            res = res | (bc << (32 * j + 8 * k + 4 + 2 * r));
          end
        end
      end
    end
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkBeat(input string name, input logic [DW-1:0] d,
                           input logic [1:0] b, input logic l);
    checkOutput({name, "_valid"}, DW'(out_valid), DW'(1'b1));
    checkOutput({name, "_data"}, out_data, d);
    checkOutput({name, "_beat"}, DW'(out_beat), DW'(b));
    checkOutput({name, "_last"}, DW'(out_last), DW'(l));
  endtask

  // Called just after a negedge; holds the word until it is accepted and
  // returns at the negedge following the accepting edge.
  task automatic applyStimulus(input logic [DW-1:0] d, input logic [2:0] m);
    logic took;
    int   guard;
    in_valid        = 1'b1;
    data_in         = d;
    weight_bitwidth = m;
    took            = 1'b0;
    guard           = 0;
    while (!took && guard < 40) begin
      #4;
      took = in_ready;
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    if (!took) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: word %h never accepted", d);
    end
  endtask

  // Monitor: checks outputs mid-cycle, samples handshakes just before the
  // rising edge, then updates the model at the edge.
  always begin
    logic          cap_rst;
    logic          cap_in;
    logic          cap_out;
    logic [DW-1:0] cap_data;
    logic [2:0]    cap_mode;
    logic          exp_rdy;
    int            nb;
    beat_t         e;
    @(negedge clk);
    if (just_reset) begin
      checkOutput("rst_out_data", out_data, '0);
      checkOutput("rst_out_last", DW'(out_last), '0);
      checkOutput("rst_out_beat", DW'(out_beat), '0);
      just_reset = 1'b0;
    end
    checkOutput("mon_out_valid", DW'(out_valid), DW'(q.size() != 0));
    if (out_valid && q.size() != 0) begin
      checkOutput("mon_out_data", out_data, q[0].data);
      checkOutput("mon_out_last", DW'(out_last), DW'(q[0].last));
      checkOutput("mon_out_beat", DW'(out_beat), DW'(q[0].beat));
    end
    checkOutput("mon_err_mode", DW'(err_mode), DW'(err_model));
    #4;
    cap_rst  = RST;
    cap_in   = in_valid && in_ready;
    cap_out  = out_valid && out_ready;
    cap_data = data_in;
    cap_mode = weight_bitwidth;
    exp_rdy  = !RST && (q.size() == 0 || (q.size() == 1 && out_ready));
    checkOutput("mon_in_ready", DW'(in_ready), DW'(exp_rdy));
    @(posedge clk);
    if (cap_rst) begin
      q.delete();
      err_model  = 1'b0;
      just_reset = 1'b1;
    end else begin
      if (cap_out && q.size() != 0) void'(q.pop_front());
      if (cap_in) begin
        case (cap_mode)
          3'b100:  nb = 4;
          3'b010:  nb = 2;
          default: nb = 1;
        endcase
        if (!(cap_mode == 3'b001 || cap_mode == 3'b010 || cap_mode == 3'b100))
          err_model = 1'b1;
        for (int p = 0; p < nb; p++) begin
          e.data = modelBeat(cap_data, cap_mode, p);
          e.last = (p == nb - 1);
          e.beat = 2'(p);
          q.push_back(e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST             = 1'b1;
    in_valid        = 1'b0;
    out_ready       = 1'b1;
    data_in         = '0;
    weight_bitwidth = 3'b100;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", DW'(in_ready), '0);
    checkOutput("rst_out_valid", DW'(out_valid), '0);
    checkOutput("rst_err_mode", DW'(err_mode), '0);
    RST = 1'b0;
    @(negedge clk);

    $display("[TB] 8-bit mode, single word");
    applyStimulus(32'h0000_00E4, 3'b100);
    in_valid = 1'b0;
    checkBeat("t1_b0", 32'hFFAA_5500, 2'd0, 1'b0);
    checkOutput("t1_rdy0", DW'(in_ready), '0);
    for (int p = 1; p < 4; p++) begin
      @(negedge clk);
      checkBeat("t1_bn", 32'h0, 2'(p), p == 3);
      checkOutput("t1_rdyn", DW'(in_ready), DW'(p == 3));
    end

    $display("[TB] 4-bit mode, single word");
    applyStimulus(32'h0000_FF00, 3'b010);
    in_valid = 1'b0;
    checkBeat("t2_b0", 32'hF0F0_F0F0, 2'd0, 1'b0);
    @(negedge clk);
    checkBeat("t2_b1", 32'h0, 2'd1, 1'b1);

    $display("[TB] 2-bit mode, back-to-back words");
    applyStimulus(32'h1234_5678, 3'b001);
    checkBeat("t3_w0", 32'h1234_5678, 2'd0, 1'b1);
    applyStimulus(32'h9ABC_DEF0, 3'b001);
    checkBeat("t3_w1", 32'h9ABC_DEF0, 2'd0, 1'b1);
    applyStimulus(32'h0F0F_0F0F, 3'b001);
    checkBeat("t3_w2", 32'h0F0F_0F0F, 2'd0, 1'b1);
    in_valid = 1'b0;

    $display("[TB] 8-bit mode with backpressure at beat 1");
    applyStimulus(32'h1B2D_4E93, 3'b100);
    in_valid = 1'b0;
    checkBeat("t4_b0", 32'hAA55_00FF, 2'd0, 1'b0);
    @(negedge clk);
    checkBeat("t4_b1", 32'h5500_FFAA, 2'd1, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkBeat("t4_hold", 32'h5500_FFAA, 2'd1, 1'b0);
      #4;
      checkOutput("t4_hold_rdy", DW'(in_ready), '0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkBeat("t4_b2", 32'h00AA_FF55, 2'd2, 1'b0);
    @(negedge clk);
    checkBeat("t4_b3", 32'h0055_AAFF, 2'd3, 1'b1);

    $display("[TB] mode change while busy, then illegal mode");
    applyStimulus(32'h1B2D_4E93, 3'b100);
    in_valid        = 1'b0;
    weight_bitwidth = 3'b001;
    checkBeat("t5_b0", 32'hAA55_00FF, 2'd0, 1'b0);
    @(negedge clk);
    checkBeat("t5_b1", 32'h5500_FFAA, 2'd1, 1'b0);
    @(negedge clk);
    checkBeat("t5_b2", 32'h00AA_FF55, 2'd2, 1'b0);
    @(negedge clk);
    checkBeat("t5_b3", 32'h0055_AAFF, 2'd3, 1'b1);
    applyStimulus(32'hFFFF_FFFF, 3'b011);
    in_valid = 1'b0;
    checkBeat("t5_ill", 32'h0, 2'd0, 1'b1);
    checkOutput("t5_err", DW'(err_mode), DW'(1'b1));
    repeat (3) @(negedge clk);
    checkOutput("t5_err_sticky", DW'(err_mode), DW'(1'b1));
    checkOutput("t5_drained", DW'(out_valid), '0);

    $display("[TB] reset in the middle of an 8-bit word");
    applyStimulus(32'h1B2D_4E93, 3'b100);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkBeat("t6_b2", 32'h00AA_FF55, 2'd2, 1'b0);
    RST = 1'b1;
    @(negedge clk);
    checkOutput("t6_rst_valid", DW'(out_valid), '0);
    checkOutput("t6_rst_data", out_data, '0);
    checkOutput("t6_rst_beat", DW'(out_beat), '0);
    checkOutput("t6_rst_err", DW'(err_mode), '0);
    RST = 1'b0;
    @(negedge clk);
    applyStimulus(32'h0000_FF00, 3'b010);
    in_valid = 1'b0;
    checkBeat("t6_n0", 32'hF0F0_F0F0, 2'd0, 1'b0);
    @(negedge clk);
    checkBeat("t6_n1", 32'h0, 2'd1, 1'b1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
